// File: rtl/mem_port_responder.sv
// mem_port_responder
// Arbitrates two CPU memory ports onto a single downstream memory port.
// Port A is a read-only instruction port, port B is a read/write data port.
// When both ports request in the same IDLE cycle, the port that was not
// granted last wins.
// All downstream outputs are driven from registers captured at grant time.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   mem_addr1, mem_read1  port A request
//   mem_rdata1, resp_a    port A read data and one-cycle completion pulse
//   mem_addr2, mem_read2, mem_write2, mem_wdata2, mem_byte_enable2
//                         port B request (read+write together is a write)
//   mem_rdata2, resp_b    port B read data and one-cycle completion pulse
//   pmem_address, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable
//                         downstream request
//   pmem_rdata, pmem_resp downstream read data and completion
module mem_port_responder (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mem_addr1,
    input  logic        mem_read1,
    output logic [15:0] mem_rdata1,
    output logic        resp_a,
    input  logic [15:0] mem_addr2,
    input  logic        mem_read2,
    input  logic        mem_write2,
    input  logic [15:0] mem_wdata2,
    input  logic [1:0]  mem_byte_enable2,
    output logic [15:0] mem_rdata2,
    output logic        resp_b,
    output logic [15:0] pmem_address,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_byte_enable,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [2:0] {
        IDLE,
        BUSY_A,
        BUSY_B,
        RESP_A,
        RESP_B
    } state_t;

    state_t      state;
    logic        last_grant;   // 0 = port A granted last, 1 = port B
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [1:0]  be_q;
    logic [15:0] rdata1_q;
    logic [15:0] rdata2_q;

    logic req_a;
    logic req_b;
    logic grant_b;

    assign req_a   = mem_read1;
    assign req_b   = mem_read2 | mem_write2;
    // B wins when alone, or on a conflict when A was granted last.
    assign grant_b = req_b & (~req_a | ~last_grant);

    assign pmem_address     = addr_q;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;
    assign mem_rdata1       = rdata1_q;
    assign mem_rdata2       = rdata2_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            resp_a     <= 1'b0;
            resp_b     <= 1'b0;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            be_q       <= '0;
            rdata1_q   <= '0;
            rdata2_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            resp_a <= 1'b0;
            resp_b <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_b) begin
                        state      <= BUSY_B;
                        last_grant <= 1'b1;
                        addr_q     <= mem_addr2;
                        wdata_q    <= mem_wdata2;
                        // read+write together is treated as a write
                        if (mem_write2) begin
                            pmem_write <= 1'b1;
                            pmem_read  <= 1'b0;
                            be_q       <= mem_byte_enable2;
                        end else begin
                            pmem_write <= 1'b0;
                            pmem_read  <= 1'b1;
                            be_q       <= 2'b11;
                        end
                    end else if (req_a) begin
                        state      <= BUSY_A;
                        last_grant <= 1'b0;
                        addr_q     <= mem_addr1;
                        pmem_read  <= 1'b1;
                        pmem_write <= 1'b0;
                        be_q       <= 2'b11;
                    end
                end
                BUSY_A: begin
                    if (pmem_resp) begin
                        rdata1_q   <= pmem_rdata;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        resp_a     <= 1'b1;
                        state      <= RESP_A;
                    end
                end
                BUSY_B: begin
                    if (pmem_resp) begin
                        // pmem_read still holds the captured op here
                        if (pmem_read) begin
                            rdata2_q <= pmem_rdata;
                        end
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        resp_b     <= 1'b1;
                        state      <= RESP_B;
                    end
                end
                RESP_A:  state <= IDLE;
                RESP_B:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_responder.sv
// tb_mem_port_responder
// Directed bench for mem_port_responder: drives the two CPU ports and plays
// the downstream memory by hand, comparing outputs to hand-computed values.
module tb_mem_port_responder;

    logic        clk;
    logic        reset_n;
    logic [15:0] mem_addr1;
    logic        mem_read1;
    logic [15:0] mem_rdata1;
    logic        resp_a;
    logic [15:0] mem_addr2;
    logic        mem_read2;
    logic        mem_write2;
    logic [15:0] mem_wdata2;
    logic [1:0]  mem_byte_enable2;
    logic [15:0] mem_rdata2;
    logic        resp_b;
    logic [15:0] pmem_address;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    int unsigned checks;
    int unsigned failures;
    logic        watch;

    mem_port_responder dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .mem_addr1        (mem_addr1),
        .mem_read1        (mem_read1),
        .mem_rdata1       (mem_rdata1),
        .resp_a           (resp_a),
        .mem_addr2        (mem_addr2),
        .mem_read2        (mem_read2),
        .mem_write2       (mem_write2),
        .mem_wdata2       (mem_wdata2),
        .mem_byte_enable2 (mem_byte_enable2),
        .mem_rdata2       (mem_rdata2),
        .resp_b           (resp_b),
        .pmem_address     (pmem_address),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_wdata       (pmem_wdata),
        .pmem_byte_enable (pmem_byte_enable),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // mutual exclusion of responses and strobes, every cycle out of reset
    always @(negedge clk) begin
        if (watch && reset_n) begin
            check("resp_excl", 16'(resp_a & resp_b), 16'd0);
            check("strobe_excl", 16'(pmem_read & pmem_write), 16'd0);
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        watch    = 1'b0;
        reset_n  = 1'b0;
        mem_addr1 = '0; mem_read1 = 1'b0;
        mem_addr2 = '0; mem_read2 = 1'b0; mem_write2 = 1'b0;
        mem_wdata2 = '0; mem_byte_enable2 = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;

        do_reset();
        check("rst_resp_a", 16'(resp_a), 16'd0);
        check("rst_resp_b", 16'(resp_b), 16'd0);
        check("rst_pread", 16'(pmem_read), 16'd0);
        check("rst_pwrite", 16'(pmem_write), 16'd0);
        check("rst_be", 16'(pmem_byte_enable), 16'd0);
        check("rst_rdata1", mem_rdata1, 16'h0000);
        check("rst_rdata2", mem_rdata2, 16'h0000);
        watch = 1'b1;

        // Port A read, zero wait states
        mem_addr1 = 16'h1000; mem_read1 = 1'b1;
        tick();
        check("a_pread", 16'(pmem_read), 16'd1);
        check("a_pwrite", 16'(pmem_write), 16'd0);
        check("a_addr", pmem_address, 16'h1000);
        check("a_be", 16'(pmem_byte_enable), 16'h0003);
        pmem_resp = 1'b1; pmem_rdata = 16'h1234;
        tick();
        check("a_resp", 16'(resp_a), 16'd1);
        check("a_rdata", mem_rdata1, 16'h1234);
        check("a_pread_off", 16'(pmem_read), 16'd0);
        mem_read1 = 1'b0; pmem_resp = 1'b0; pmem_rdata = 16'h0000;
        tick();
        check("a_resp_end", 16'(resp_a), 16'd0);
        check("a_idle_pread", 16'(pmem_read), 16'd0);

        // Port B read to give mem_rdata2 a known value
        mem_addr2 = 16'h2000; mem_read2 = 1'b1;
        tick();
        check("b_rd_pread", 16'(pmem_read), 16'd1);
        check("b_rd_addr", pmem_address, 16'h2000);
        pmem_resp = 1'b1; pmem_rdata = 16'h5A5A;
        tick();
        check("b_rd_resp", 16'(resp_b), 16'd1);
        check("b_rd_data", mem_rdata2, 16'h5A5A);
        mem_read2 = 1'b0; pmem_resp = 1'b0; pmem_rdata = 16'h0000;
        tick();

        // Port B write, 3 wait states; CPU-side inputs change mid-flight
        mem_addr2 = 16'h2002; mem_wdata2 = 16'hBEEF; mem_byte_enable2 = 2'b10;
        mem_write2 = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("w_pwrite", 16'(pmem_write), 16'd1);
            check("w_pread", 16'(pmem_read), 16'd0);
            check("w_addr", pmem_address, 16'h2002);
            check("w_wdata", pmem_wdata, 16'hBEEF);
            check("w_be", 16'(pmem_byte_enable), 16'h0002);
            check("w_no_resp", 16'(resp_b), 16'd0);
            mem_addr2 = 16'hFFFF; mem_wdata2 = 16'h0000; mem_byte_enable2 = 2'b01;
            if (i == 3) begin
                pmem_resp = 1'b1; pmem_rdata = 16'hDEAD;
            end
            tick();
        end
        check("w_resp", 16'(resp_b), 16'd1);
        check("w_pwrite_off", 16'(pmem_write), 16'd0);
        check("w_rdata2_kept", mem_rdata2, 16'h5A5A);
        mem_write2 = 1'b0; pmem_resp = 1'b0;
        tick();
        check("w_single_resp", 16'(resp_b), 16'd0);

        // Requester drops mid-transaction: still completes
        mem_addr1 = 16'h0042; mem_read1 = 1'b1;
        tick();
        mem_read1 = 1'b0;
        tick();
        check("drop_pread", 16'(pmem_read), 16'd1);
        pmem_resp = 1'b1; pmem_rdata = 16'h7777;
        tick();
        check("drop_resp", 16'(resp_a), 16'd1);
        check("drop_rdata", mem_rdata1, 16'h7777);
        pmem_resp = 1'b0;
        tick();

        // Conflicts after reset: B first, then A wins the next conflict
        do_reset();
        mem_addr1 = 16'h3000; mem_read1 = 1'b1;
        mem_addr2 = 16'h4000; mem_read2 = 1'b1;
        tick();
        check("c1_addr_b", pmem_address, 16'h4000);
        check("c1_pread", 16'(pmem_read), 16'd1);
        pmem_resp = 1'b1; pmem_rdata = 16'hBBBB;
        tick();
        check("c1_resp_b", 16'(resp_b), 16'd1);
        check("c1_resp_a", 16'(resp_a), 16'd0);
        check("c1_rdata2", mem_rdata2, 16'hBBBB);
        pmem_resp = 1'b0;
        mem_addr2 = 16'h4002;      // B immediately asks again
        tick();
        check("c1_no_grant", 16'(pmem_read), 16'd0);
        tick();
        check("c2_addr_a", pmem_address, 16'h3000);
        pmem_resp = 1'b1; pmem_rdata = 16'hAAAA;
        tick();
        check("c2_resp_a", 16'(resp_a), 16'd1);
        check("c2_rdata1", mem_rdata1, 16'hAAAA);
        pmem_resp = 1'b0;
        tick();
        tick();
        check("c3_addr_b", pmem_address, 16'h4002);
        pmem_resp = 1'b1; pmem_rdata = 16'hCCCC;
        tick();
        check("c3_resp_b", 16'(resp_b), 16'd1);
        check("c3_rdata2", mem_rdata2, 16'hCCCC);
        mem_read2 = 1'b0; pmem_resp = 1'b0;
        tick();
        tick();
        check("c4_addr_a", pmem_address, 16'h3000);
        pmem_resp = 1'b1;
        tick();
        check("c4_resp_a", 16'(resp_a), 16'd1);
        mem_read1 = 1'b0; pmem_resp = 1'b0;
        tick();

        // Reset during BUSY_B abandons the transaction
        mem_addr2 = 16'h5000; mem_wdata2 = 16'h1111; mem_byte_enable2 = 2'b11;
        mem_write2 = 1'b1;
        tick();
        check("rb_pwrite", 16'(pmem_write), 16'd1);
        reset_n = 1'b0; mem_write2 = 1'b0;
        tick();
        check("rb_pwrite_off", 16'(pmem_write), 16'd0);
        check("rb_no_resp", 16'(resp_b), 16'd0);
        check("rb_rdata1_clr", mem_rdata1, 16'h0000);
        reset_n = 1'b1;
        pmem_resp = 1'b1;           // spurious response in IDLE
        tick();
        check("sp_no_resp_b", 16'(resp_b), 16'd0);
        check("sp_no_resp_a", 16'(resp_a), 16'd0);

        // Read+write together becomes a write; spurious pmem_resp still high
        mem_addr2 = 16'h6000; mem_wdata2 = 16'h1357; mem_byte_enable2 = 2'b01;
        mem_read2 = 1'b1; mem_write2 = 1'b1;
        tick();
        check("rw_pwrite", 16'(pmem_write), 16'd1);
        check("rw_pread", 16'(pmem_read), 16'd0);
        check("rw_be", 16'(pmem_byte_enable), 16'h0001);
        check("rw_wdata", pmem_wdata, 16'h1357);
        check("rw_no_resp", 16'(resp_b), 16'd0);
        pmem_resp = 1'b0;
        tick();
        check("rw_hold", 16'(pmem_write), 16'd1);
        pmem_resp = 1'b1; pmem_rdata = 16'h9999;
        tick();
        check("rw_resp", 16'(resp_b), 16'd1);
        check("rw_rdata2_kept", mem_rdata2, 16'h0000);
        mem_read2 = 1'b0; mem_write2 = 1'b0; pmem_resp = 1'b0;
        tick();
        check("rw_resp_end", 16'(resp_b), 16'd0);

        watch = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
